// File: rtl/fifo_rd_checker_pkg.sv
// Shared constants for the FIFO read-side checker: LFSR taps, seeds, latency width and FSM states.
// The write-side generator imports the same seed and taps so both ends produce one sequence.
package fifo_rd_checker_pkg;

   // Feedback taps q[7], q[5], q[4], q[3] of the 8-bit Fibonacci LFSR.
   localparam logic [7:0] LFSR_TAPS        = 8'hB8;
   localparam logic [7:0] DEFAULT_SEED     = 8'h01;
   localparam logic [7:0] DEFAULT_THR_SEED = 8'hA5;

   // Wide enough for RD_LAT-1 with RD_LAT in 1..3.
   localparam int LAT_W = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_POLL,
      ST_READ,
      ST_WAIT,
      ST_CHECK,
      ST_DONE
   } state_e;

   function automatic logic [7:0] lfsr8_next(input logic [7:0] q);
      return {q[6:0], ^(q & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/fifo_rd_checker_if.sv
// FIFO read port: the consumer (master) drives rd, the FIFO (slave) drives empty and d_out.
interface fifo_rd_checker_if #(
   parameter int unsigned DW = 8
) ();

   logic          rd;
   logic          empty;
   logic [DW-1:0] d_out;

   modport master (output rd, input empty, input d_out);
   modport slave  (input rd, output empty, output d_out);

endinterface

// File: rtl/fifo_rd_checker_lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous seed load and advance enable; load wins over advance.
module fifo_rd_checker_lfsr8
   import fifo_rd_checker_pkg::*;
#(
   parameter logic [7:0] SEED = DEFAULT_SEED
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_i,
   input  logic       en_i,
   output logic [7:0] q_o
);

   logic [7:0] q_q;
   logic [7:0] q_d;

   always_comb begin
      q_d = q_q;
      if (load_i) begin
         q_d = SEED;
      end else if (en_i) begin
         q_d = lfsr8_next(q_q);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= SEED;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/fifo_rd_checker.sv
// Read-domain consumer and scoreboard: pops the FIFO, compares each word with a regenerated
// copy of the write-side LFSR stream, and reports counts, first-mismatch details and completion.
module fifo_rd_checker
   import fifo_rd_checker_pkg::*;
#(
   parameter int unsigned DW        = 8,
   parameter int unsigned CW        = 16,
   parameter logic [7:0]  SEED      = DEFAULT_SEED,
   parameter int unsigned NUM_WORDS = 10000,
   parameter int unsigned RD_LAT    = 1,
   parameter bit          THROTTLE  = 1'b0,
   parameter logic [7:0]  THR_SEED  = DEFAULT_THR_SEED
) (
   input  logic                 rd_clk_in,
   input  logic                 rst,
   input  logic                 en,
   fifo_rd_checker_if.master    fifo,
   output logic [DW-1:0]        exp_data,
   output logic [CW-1:0]        rd_count,
   output logic [CW-1:0]        err_count,
   output logic [CW-1:0]        first_err_idx,
   output logic [DW-1:0]        first_err_got,
   output logic                 err_flag,
   output logic                 done
);

   state_e           state_q, state_d;
   logic [CW-1:0]    rd_count_q, rd_count_d;
   logic [CW-1:0]    err_count_q, err_count_d;
   logic [CW-1:0]    first_err_idx_q, first_err_idx_d;
   logic [DW-1:0]    first_err_got_q, first_err_got_d;
   logic             err_flag_q, err_flag_d;
   logic [LAT_W-1:0] lat_q, lat_d;

   logic             data_load;
   logic             data_adv;
   logic             thr_adv;
   logic [7:0]       data_q;
   logic [7:0]       thr_q;
   logic             unused_thr;
   logic [CW-1:0]    rd_count_inc;
   logic             mismatch;

   fifo_rd_checker_lfsr8 #(.SEED(SEED)) u_data_lfsr (
      .clk    (rd_clk_in),
      .rst_n  (rst),
      .load_i (data_load),
      .en_i   (data_adv),
      .q_o    (data_q)
   );

   fifo_rd_checker_lfsr8 #(.SEED(THR_SEED)) u_thr_lfsr (
      .clk    (rd_clk_in),
      .rst_n  (rst),
      .load_i (1'b0),
      .en_i   (thr_adv),
      .q_o    (thr_q)
   );

   // Only bit 0 of the throttle LFSR gates read attempts.
   assign unused_thr   = ^thr_q[7:1];
   assign exp_data     = DW'(data_q);
   assign rd_count_inc = rd_count_q + CW'(1);
   assign mismatch     = (fifo.d_out != exp_data);

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      state_d         = state_q;
      rd_count_d      = rd_count_q;
      err_count_d     = err_count_q;
      first_err_idx_d = first_err_idx_q;
      first_err_got_d = first_err_got_q;
      err_flag_d      = err_flag_q;
      lat_d           = lat_q;
      data_load       = 1'b0;
      data_adv        = 1'b0;
      thr_adv         = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (en) begin
               rd_count_d      = '0;
               err_count_d     = '0;
               first_err_idx_d = '0;
               first_err_got_d = '0;
               err_flag_d      = 1'b0;
               data_load       = 1'b1;
               state_d         = ST_POLL;
            end
         end
         ST_POLL: begin
            thr_adv = 1'b1;
            if (!en) begin
               state_d = ST_IDLE;
            end else if (!fifo.empty && (!THROTTLE || thr_q[0])) begin
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            lat_d   = LAT_W'(RD_LAT - 1);
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (lat_q == '0) begin
               state_d = ST_CHECK;
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         ST_CHECK: begin
            if (mismatch) begin
               if (err_count_q != {CW{1'b1}}) begin
                  err_count_d = err_count_q + CW'(1);
               end
               if (!err_flag_q) begin
                  first_err_idx_d = rd_count_q;
                  first_err_got_d = fifo.d_out;
                  err_flag_d      = 1'b1;
               end
            end
            // The expected stream advances regardless, so one bad word costs one error.
            data_adv   = 1'b1;
            rd_count_d = rd_count_inc;
            state_d    = (rd_count_inc == CW'(NUM_WORDS)) ? ST_DONE : ST_POLL;
         end
         ST_DONE: begin
            if (!en) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge rd_clk_in or negedge rst) begin
      if (!rst) begin
         state_q         <= ST_IDLE;
         rd_count_q      <= '0;
         err_count_q     <= '0;
         first_err_idx_q <= '0;
         first_err_got_q <= '0;
         err_flag_q      <= 1'b0;
         lat_q           <= '0;
      end else begin
         state_q         <= state_d;
         rd_count_q      <= rd_count_d;
         err_count_q     <= err_count_d;
         first_err_idx_q <= first_err_idx_d;
         first_err_got_q <= first_err_got_d;
         err_flag_q      <= err_flag_d;
         lat_q           <= lat_d;
      end
   end

   // Decoded from state so a reset removes the pop request in the same instant.
   assign fifo.rd       = (state_q == ST_READ);
   assign done          = (state_q == ST_DONE);
   assign rd_count      = rd_count_q;
   assign err_count     = err_count_q;
   assign first_err_idx = first_err_idx_q;
   assign first_err_got = first_err_got_q;
   assign err_flag      = err_flag_q;

endmodule
